lane_deskew_ctrl: RTL and testbench
===================================

LANE_DESKEW_CTRL -- requirements
Module: lane_deskew_ctrl

Interface
REQ-001 SHALL have parameter COM, default 8'hBC, alignment symbol searched on both lanes.
REQ-002 SHALL have parameter MAX_SKEW, default 3, maximum lane-to-lane skew in clk_f cycles; legal range 1..7.
REQ-003 SHALL have port clk_f  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports lane_0, lane_1  input  8 each  raw lane bytes.
REQ-006 SHALL have ports valid_0, valid_1  input  1 each  lane byte qualifiers.
REQ-007 SHALL have ports lane_0_out, lane_1_out  output  8 each  deskewed bytes to the unstriping datapath.
REQ-008 SHALL have port valid_out  output  1  deskewed pair valid.
REQ-009 SHALL have port locked  output  1  high while in LOCKED.
REQ-010 SHALL have port skew  output  3  measured skew in cycles.
REQ-011 SHALL have port early_lane  output  1  lane whose COM arrived first (0/1).
REQ-012 SHALL have port err  output  1  one-cycle error pulse.
REQ-013 SHALL have port err_count  output  8  error counter; see Configuration.

Function
REQ-014 COM hit on lane x SHALL mean valid_x==1 and lane_x==COM in the same cycle.
REQ-015 SHALL implement states IDLE, SEARCH, WAIT, LOCKED; IDLE SHALL go to SEARCH one cycle after reset deasserts.
REQ-016 SEARCH: hits on both lanes in the same cycle SHALL set skew=0, early_lane=0, go LOCKED.
REQ-017 SEARCH: hit on one lane only SHALL record early_lane, load cnt=1, go WAIT.
REQ-018 WAIT: hit on the late lane SHALL set skew=cnt, go LOCKED; otherwise cnt SHALL increment.
REQ-019 WAIT: hit on the early lane again, hits on both lanes, or no late hit when cnt==MAX_SKEW SHALL pulse err and go SEARCH.
REQ-020 Both lanes SHALL continuously shift through MAX_SKEW-deep delay lines in every state, each stage carrying byte and valid.
REQ-021 LOCKED: early lane SHALL be taken from delay tap skew (tap 0 = undelayed), late lane from tap 0; both SHALL then be registered once to lane_x_out.
REQ-022 Latency SHALL be 1 cycle for the late lane and skew+1 cycles for the early lane.
REQ-023 valid_out SHALL equal the AND of both aligned valids while locked, and 0 otherwise.
REQ-024 lane_x_out SHALL hold 8'h00 when not locked.
REQ-025 LOCKED: aligned pair both valid with COM on exactly one lane SHALL pulse err, go SEARCH; locked SHALL drop on the following cycle.
REQ-026 skew and early_lane SHALL hold their values until the next successful lock or reset.
REQ-027 err SHALL never be high for two consecutive cycles.

Reset
REQ-028 reset high at any clock edge SHALL force IDLE, clear delay lines, cnt, skew, early_lane.
REQ-029 While in reset, outputs SHALL be: lane_x_out=0, valid_out=0, locked=0, err=0, err_count=0.
REQ-030 Reset asserted during WAIT or LOCKED SHALL abort without an err pulse.

Configuration
REQ-031 With LANE_DESKEW_ERRCNT_EN defined, err_count SHALL increment on each err pulse, saturating at 8'hFF, cleared only by reset.
REQ-032 Without LANE_DESKEW_ERRCNT_EN, err_count SHALL be tied to 8'h00 and no counter logic SHALL exist.

Verification
REQ-033 Both lanes carry BC in same cycle, then 01/02 -> locked=1, skew=0, outputs 01/02 one cycle after input.
REQ-034 lane_1 carries BC two cycles after lane_0 -> skew=2, early_lane=0, BC pair emerges aligned with valid_out=1 and lane_1 latency 1.
REQ-035 lane_0 BC, lane_1 BC never (MAX_SKEW=3) -> err pulse 3 cycles after the lane_0 hit, state SEARCH, locked=0.
REQ-036 Locked at skew=1, then BC on lane_0_out with 55 on lane_1_out -> err=1 one cycle, locked=0 next cycle, err_count=1 (macro defined) or 0 (undefined).
REQ-037 reset pulsed for one cycle while locked -> next cycle locked=0, valid_out=0, outputs 00, skew=0, err=0.
REQ-038 300 forced timeouts with macro defined -> err_count saturates at 8'hFF.

Source files
------------

// File: rtl/lane_deskew_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lane_deskew_ctrl
// Brief    : Two-lane COM-symbol deskew controller ahead of the unstriping
//            datapath. Optional error counter: LANE_DESKEW_ERRCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lane_deskew_ctrl #(
    parameter logic [7:0] COM      = 8'hBC,
    parameter int         MAX_SKEW = 3
) (
    input  logic       clk_f,
    input  logic       reset,
    input  logic [7:0] lane_0,
    input  logic [7:0] lane_1,
    input  logic       valid_0,
    input  logic       valid_1,
    output logic [7:0] lane_0_out,
    output logic [7:0] lane_1_out,
    output logic       valid_out,
    output logic       locked,
    output logic [2:0] skew,
    output logic       early_lane,
    output logic       err,
    output logic [7:0] err_count
);

    localparam logic [2:0] c_MAX_SKEW = 3'(MAX_SKEW);
    localparam int         c_TAPS     = MAX_SKEW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic [2:0] r_skew;
    logic [2:0] w_skew_nxt;
    logic       r_early;
    logic       w_early_nxt;
    logic       r_pend;
    logic       w_pend_nxt;
    logic       w_err;

    // {valid, byte}; stage k holds the lane symbol delayed by k+1 cycles
    logic [8:0] r_dly_0 [MAX_SKEW];
    logic [8:0] r_dly_1 [MAX_SKEW];
    logic [8:0] w_tap_0 [c_TAPS];
    logic [8:0] w_tap_1 [c_TAPS];
    logic [8:0] w_early_sym;
    logic [8:0] w_aligned_0;
    logic [8:0] w_aligned_1;

    logic [7:0] r_out_0;
    logic [7:0] r_out_1;
    logic       r_valid_out;

    logic       w_hit_0;
    logic       w_hit_1;
    logic       w_early_hit;
    logic       w_late_hit;
    logic       w_pair_bad;

    assign w_hit_0     = valid_0 && (lane_0 == COM);
    assign w_hit_1     = valid_1 && (lane_1 == COM);
    // r_pend is the lane whose COM opened the current WAIT window
    assign w_early_hit = r_pend ? w_hit_1 : w_hit_0;
    assign w_late_hit  = r_pend ? w_hit_0 : w_hit_1;
    assign w_pair_bad  = r_valid_out && ((r_out_0 == COM) != (r_out_1 == COM));

    always_ff @(posedge clk_f) begin : p_delay
        if (reset) begin
            for (int k = 0; k < MAX_SKEW; k++) begin
                r_dly_0[k] <= '0;
                r_dly_1[k] <= '0;
            end
        end else begin
            r_dly_0[0] <= {valid_0, lane_0};
            r_dly_1[0] <= {valid_1, lane_1};
            for (int k = 1; k < MAX_SKEW; k++) begin
                r_dly_0[k] <= r_dly_0[k-1];
                r_dly_1[k] <= r_dly_1[k-1];
            end
        end
    end

    always_comb begin : p_taps
        w_tap_0[0] = {valid_0, lane_0};
        w_tap_1[0] = {valid_1, lane_1};
        for (int k = 1; k < c_TAPS; k++) begin
            w_tap_0[k] = r_dly_0[k-1];
            w_tap_1[k] = r_dly_1[k-1];
        end
    end

    always_comb begin : p_fsm_nxt
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_skew_nxt  = r_skew;
        w_early_nxt = r_early;
        w_pend_nxt  = r_pend;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_SEARCH;
            end
            ST_SEARCH: begin
                if (w_hit_0 && w_hit_1) begin
                    w_skew_nxt  = 3'd0;
                    w_early_nxt = 1'b0;
                    w_state_nxt = ST_LOCKED;
                end else if (w_hit_0 || w_hit_1) begin
                    w_pend_nxt  = w_hit_1;
                    w_cnt_nxt   = 3'd1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // a repeated early COM (alone or with the late one) breaks the window
                if (w_early_hit) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_SEARCH;
                end else if (w_late_hit) begin
                    w_skew_nxt  = r_cnt;
                    w_early_nxt = r_pend;
                    w_state_nxt = ST_LOCKED;
                end else if (r_cnt == c_MAX_SKEW) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_SEARCH;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            ST_LOCKED: begin
                if (w_pair_bad) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_SEARCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_f) begin : p_fsm_reg
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_skew  <= 3'd0;
            r_early <= 1'b0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_skew  <= w_skew_nxt;
            r_early <= w_early_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Alignment uses the skew being committed, so the COM pair that completes
    // the lock is itself forwarded on the first locked cycle.
    always_comb begin : p_align
        w_early_sym = '0;
        for (int k = 0; k < c_TAPS; k++) begin
            if (w_skew_nxt == 3'(k)) begin
                w_early_sym = w_early_nxt ? w_tap_1[k] : w_tap_0[k];
            end
        end
        w_aligned_0 = w_early_nxt ? w_tap_0[0] : w_early_sym;
        w_aligned_1 = w_early_nxt ? w_early_sym : w_tap_1[0];
    end

    always_ff @(posedge clk_f) begin : p_out
        if (reset || (w_state_nxt != ST_LOCKED)) begin
            r_out_0     <= 8'h00;
            r_out_1     <= 8'h00;
            r_valid_out <= 1'b0;
        end else begin
            r_out_0     <= w_aligned_0[7:0];
            r_out_1     <= w_aligned_1[7:0];
            r_valid_out <= w_aligned_0[8] && w_aligned_1[8];
        end
    end

    assign lane_0_out = reset ? 8'h00 : r_out_0;
    assign lane_1_out = reset ? 8'h00 : r_out_1;
    assign valid_out  = r_valid_out && !reset;
    assign locked     = (r_state == ST_LOCKED) && !reset;
    assign skew       = r_skew;
    assign early_lane = r_early;
    assign err        = w_err && !reset;

`ifdef LANE_DESKEW_ERRCNT_EN
    logic [7:0] r_err_count;

    always_ff @(posedge clk_f) begin : p_errcnt
        if (reset) begin
            r_err_count <= 8'h00;
        end else if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = reset ? 8'h00 : r_err_count;
`else
    assign err_count = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lane_deskew_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lane_deskew_ctrl
// Brief    : Self-checking bench for lane_deskew_ctrl against a timestamp and
//            history based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lane_deskew_ctrl;

    localparam logic [7:0] c_COM      = 8'hBC;
    localparam int         c_MAX_SKEW = 3;
    localparam int         M_IDLE     = 0;
    localparam int         M_SEARCH   = 1;
    localparam int         M_WAIT     = 2;
    localparam int         M_LOCKED   = 3;
`ifdef LANE_DESKEW_ERRCNT_EN
    localparam logic [7:0] c_EC_ONE = 8'h01;
    localparam logic [7:0] c_EC_SAT = 8'hFF;
`else
    localparam logic [7:0] c_EC_ONE = 8'h00;
    localparam logic [7:0] c_EC_SAT = 8'h00;
`endif

    logic       clk_f   = 1'b0;
    logic       reset   = 1'b1;
    logic [7:0] lane_0  = 8'h00;
    logic [7:0] lane_1  = 8'h00;
    logic       valid_0 = 1'b0;
    logic       valid_1 = 1'b0;
    logic [7:0] lane_0_out;
    logic [7:0] lane_1_out;
    logic       valid_out;
    logic       locked;
    logic [2:0] skew;
    logic       early_lane;
    logic       err;
    logic [7:0] err_count;

    int tests = 0;
    int fails = 0;

    // reference model state
    int         n          = 0;
    int         m_mode     = M_IDLE;
    int         m_skew     = 0;
    int         m_hit_time = 0;
    int         m_errcnt   = 0;
    logic       m_early    = 1'b0;
    logic       m_pend     = 1'b0;
    logic       m_vout     = 1'b0;
    logic [7:0] m_out0     = 8'h00;
    logic [7:0] m_out1     = 8'h00;
    logic [7:0] hd0 [16];
    logic [7:0] hd1 [16];
    logic       hv0 [16];
    logic       hv1 [16];

    logic [30:0] exp_vec;
    logic [30:0] obs_vec;
    logic [7:0]  o_l0, o_l1, o_ec;
    logic        o_v, o_lk, o_el, o_err;
    logic [2:0]  o_sk;

    lane_deskew_ctrl #(.COM(c_COM), .MAX_SKEW(c_MAX_SKEW)) u_dut (
        .clk_f      (clk_f),
        .reset      (reset),
        .lane_0     (lane_0),
        .lane_1     (lane_1),
        .valid_0    (valid_0),
        .valid_1    (valid_1),
        .lane_0_out (lane_0_out),
        .lane_1_out (lane_1_out),
        .valid_out  (valid_out),
        .locked     (locked),
        .skew       (skew),
        .early_lane (early_lane),
        .err        (err),
        .err_count  (err_count)
    );

    always #5 clk_f = ~clk_f;

    function automatic logic [7:0] junk();
        logic [7:0] b;
        b = 8'($urandom_range(0, 255));
        if (b == c_COM) b = 8'h5A;
        return b;
    endfunction

    // Apply one cycle of stimulus, predict this cycle's outputs, sample at the
    // falling edge, then advance the model across the rising edge.
    task automatic run_cycle(input logic rst, input logic [7:0] d0, input logic v0,
                             input logic [7:0] d1, input logic v1);
        logic       h0, h1, e_hit, l_hit, e_err, lock;
        logic       ve, vl;
        logic [7:0] ec;
        int         nm, age, slot, src;
        reset = rst; lane_0 = d0; valid_0 = v0; lane_1 = d1; valid_1 = v1;
        h0    = v0 && (d0 == c_COM);
        h1    = v1 && (d1 == c_COM);
        e_hit = m_pend ? h1 : h0;
        l_hit = m_pend ? h0 : h1;
        age   = n - m_hit_time;
        e_err = 1'b0;
        if (!rst) begin
            if (m_mode == M_WAIT)
                e_err = e_hit || (!l_hit && (age == c_MAX_SKEW));
            else if (m_mode == M_LOCKED)
                e_err = m_vout && ((m_out0 == c_COM) != (m_out1 == c_COM));
        end
`ifdef LANE_DESKEW_ERRCNT_EN
        ec = rst ? 8'h00 : 8'(m_errcnt);
`else
        ec = 8'h00;
`endif
        if (rst)
            exp_vec = {8'h00, 8'h00, 1'b0, 1'b0, 3'(m_skew), m_early, 1'b0, 8'h00};
        else
            exp_vec = {m_out0, m_out1, m_vout, (m_mode == M_LOCKED), 3'(m_skew), m_early, e_err, ec};

        @(negedge clk_f);
        o_l0 = lane_0_out; o_l1 = lane_1_out; o_v = valid_out; o_lk = locked;
        o_sk = skew; o_el = early_lane; o_err = err; o_ec = err_count;
        obs_vec = {o_l0, o_l1, o_v, o_lk, o_sk, o_el, o_err, o_ec};

        slot = n % 16;
        hd0[slot] = d0; hv0[slot] = v0; hd1[slot] = d1; hv1[slot] = v1;
        if (rst) begin
            m_mode = M_IDLE; m_skew = 0; m_early = 1'b0; m_pend = 1'b0; m_errcnt = 0;
            m_out0 = 8'h00; m_out1 = 8'h00; m_vout = 1'b0;
            for (int i = 0; i < 16; i++) begin
                hd0[i] = 8'h00; hd1[i] = 8'h00; hv0[i] = 1'b0; hv1[i] = 1'b0;
            end
        end else begin
            lock = 1'b0;
            nm   = m_mode;
            case (m_mode)
                M_IDLE:   nm = M_SEARCH;
                M_SEARCH: begin
                    if (h0 && h1) begin
                        lock = 1'b1; m_skew = 0; m_early = 1'b0;
                    end else if (h0 || h1) begin
                        nm = M_WAIT; m_hit_time = n; m_pend = h1;
                    end
                end
                M_WAIT: begin
                    if (e_err) nm = M_SEARCH;
                    else if (l_hit) begin
                        lock = 1'b1; m_skew = age; m_early = m_pend;
                    end
                end
                default: begin
                    if (e_err) nm = M_SEARCH;
                    else lock = 1'b1;
                end
            endcase
            if (lock) nm = M_LOCKED;
            if (e_err && (m_errcnt < 255)) m_errcnt++;
            m_mode = nm;
            if (lock) begin
                // early lane comes from skew cycles ago, late lane from now
                src = (n - m_skew) % 16;
                if (m_early) begin
                    m_out1 = hd1[src]; ve = hv1[src]; m_out0 = d0; vl = v0;
                end else begin
                    m_out0 = hd0[src]; ve = hv0[src]; m_out1 = d1; vl = v1;
                end
                m_vout = ve && vl;
            end else begin
                m_out0 = 8'h00; m_out1 = 8'h00; m_vout = 1'b0;
            end
        end
        n++;
        @(posedge clk_f);
        #1;
    endtask

    task automatic do_reset();
        run_cycle(1'b1, junk(), 1'b1, junk(), 1'b1);
        run_cycle(1'b1, junk(), 1'b1, junk(), 1'b1);
        run_cycle(1'b0, junk(), 1'b1, junk(), 1'b1);
    endtask

    task automatic test_reset();
        run_cycle(1'b1, c_COM, 1'b1, c_COM, 1'b1);
        run_cycle(1'b1, c_COM, 1'b1, c_COM, 1'b1);
        tests++;
        if ({o_l0, o_l1, o_v, o_lk, o_err, o_ec} !== 27'd0) begin
            fails++;
            $display("FAIL reset_outputs: observed %h, required 0", {o_l0, o_l1, o_v, o_lk, o_err, o_ec});
        end
        tests++;
        if ({o_sk, o_el} !== 4'd0) begin
            fails++;
            $display("FAIL reset_skew: observed skew=%0d early=%0d, required 0/0", o_sk, o_el);
        end
        run_cycle(1'b0, c_COM, 1'b1, c_COM, 1'b1);
        run_cycle(1'b0, junk(), 1'b1, junk(), 1'b1);
        tests++;
        if (o_lk !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_ignores_hits: observed locked=%b, required 0", o_lk);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        run_cycle(1'b0, c_COM, 1'b1, c_COM, 1'b1);
        run_cycle(1'b0, 8'h01, 1'b1, 8'h02, 1'b1);
        tests++;
        if ({o_lk, o_v, o_l0, o_l1} !== {1'b1, 1'b1, c_COM, c_COM}) begin
            fails++;
            $display("FAIL same_cycle_com_pair: observed %h, required %h", {o_lk, o_v, o_l0, o_l1}, {1'b1, 1'b1, c_COM, c_COM});
        end
        run_cycle(1'b0, 8'h33, 1'b1, 8'h44, 1'b1);
        tests++;
        if ({o_l0, o_l1, o_sk, o_lk, o_v} !== {8'h01, 8'h02, 3'd0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL same_cycle_data: observed %h, required %h", {o_l0, o_l1, o_sk, o_lk, o_v}, {8'h01, 8'h02, 3'd0, 1'b1, 1'b1});
        end
        tests++;
        if (obs_vec !== exp_vec) begin
            fails++;
            $display("FAIL same_cycle_model: observed %h, required %h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_skew2();
        do_reset();
        run_cycle(1'b0, c_COM, 1'b1, 8'h11, 1'b1);
        run_cycle(1'b0, 8'h22, 1'b1, 8'h33, 1'b1);
        run_cycle(1'b0, 8'h44, 1'b1, c_COM, 1'b1);
        run_cycle(1'b0, 8'h55, 1'b1, 8'h66, 1'b1);
        tests++;
        if ({o_l0, o_l1, o_v, o_lk, o_sk, o_el} !== {c_COM, c_COM, 1'b1, 1'b1, 3'd2, 1'b0}) begin
            fails++;
            $display("FAIL skew2_lock: observed %h, required %h", {o_l0, o_l1, o_v, o_lk, o_sk, o_el}, {c_COM, c_COM, 1'b1, 1'b1, 3'd2, 1'b0});
        end
        run_cycle(1'b0, 8'h77, 1'b1, 8'h88, 1'b1);
        tests++;
        if ({o_l0, o_l1} !== {8'h22, 8'h66}) begin
            fails++;
            $display("FAIL skew2_latency: observed %h, required %h", {o_l0, o_l1}, {8'h22, 8'h66});
        end
    endtask

    task automatic test_timeout();
        do_reset();
        run_cycle(1'b0, c_COM, 1'b1, 8'h11, 1'b1);
        for (int k = 1; k <= c_MAX_SKEW; k++) begin
            run_cycle(1'b0, junk(), 1'b1, junk(), 1'b1);
            tests++;
            if (o_err !== (k == c_MAX_SKEW)) begin
                fails++;
                $display("FAIL timeout_err_cycle%0d: observed %b, required %b", k, o_err, (k == c_MAX_SKEW));
            end
        end
        run_cycle(1'b0, c_COM, 1'b1, c_COM, 1'b1);
        tests++;
        if ({o_err, o_lk} !== 2'b00) begin
            fails++;
            $display("FAIL timeout_after: observed err/locked %b, required 00", {o_err, o_lk});
        end
        run_cycle(1'b0, junk(), 1'b1, junk(), 1'b1);
        tests++;
        if (o_lk !== 1'b1) begin
            fails++;
            $display("FAIL timeout_back_to_search: observed locked=%b, required 1", o_lk);
        end
    endtask

    task automatic test_locked_err();
        do_reset();
        run_cycle(1'b0, c_COM, 1'b1, 8'h11, 1'b1);
        run_cycle(1'b0, 8'h21, 1'b1, c_COM, 1'b1);
        run_cycle(1'b0, 8'h22, 1'b1, 8'h32, 1'b1);
        tests++;
        if ({o_lk, o_sk, o_el} !== {1'b1, 3'd1, 1'b0}) begin
            fails++;
            $display("FAIL locked_err_lock: observed %h, required %h", {o_lk, o_sk, o_el}, {1'b1, 3'd1, 1'b0});
        end
        run_cycle(1'b0, c_COM, 1'b1, 8'h33, 1'b1);
        run_cycle(1'b0, 8'h23, 1'b1, 8'h55, 1'b1);
        run_cycle(1'b0, 8'h24, 1'b1, 8'h34, 1'b1);
        tests++;
        if ({o_l0, o_l1, o_err, o_lk} !== {c_COM, 8'h55, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL locked_err_pulse: observed %h, required %h", {o_l0, o_l1, o_err, o_lk}, {c_COM, 8'h55, 1'b1, 1'b1});
        end
        run_cycle(1'b0, 8'h25, 1'b1, 8'h35, 1'b1);
        tests++;
        if ({o_lk, o_err, o_ec, o_l0, o_sk} !== {1'b0, 1'b0, c_EC_ONE, 8'h00, 3'd1}) begin
            fails++;
            $display("FAIL locked_err_after: observed %h, required %h", {o_lk, o_err, o_ec, o_l0, o_sk}, {1'b0, 1'b0, c_EC_ONE, 8'h00, 3'd1});
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        run_cycle(1'b0, c_COM, 1'b1, 8'h11, 1'b1);
        run_cycle(1'b0, junk(), 1'b1, junk(), 1'b1);
        run_cycle(1'b0, junk(), 1'b1, junk(), 1'b1);
        run_cycle(1'b1, junk(), 1'b1, junk(), 1'b1);
        tests++;
        if (o_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_in_wait_err: observed %b, required 0", o_err);
        end
        do_reset();
        run_cycle(1'b0, c_COM, 1'b1, 8'h11, 1'b1);
        run_cycle(1'b0, 8'h21, 1'b1, c_COM, 1'b1);
        run_cycle(1'b0, 8'h22, 1'b1, 8'h32, 1'b1);
        run_cycle(1'b1, c_COM, 1'b1, 8'h55, 1'b1);
        tests++;
        if ({o_lk, o_v, o_err, o_l0, o_l1} !== 19'd0) begin
            fails++;
            $display("FAIL reset_in_locked: observed %h, required 0", {o_lk, o_v, o_err, o_l0, o_l1});
        end
        run_cycle(1'b0, junk(), 1'b1, junk(), 1'b1);
        tests++;
        if ({o_lk, o_v, o_l0, o_l1, o_sk, o_err} !== 22'd0) begin
            fails++;
            $display("FAIL reset_locked_after: observed %h, required 0", {o_lk, o_v, o_l0, o_l1, o_sk, o_err});
        end
    endtask

    task automatic test_random();
        logic [7:0] x [64];
        logic [7:0] a, b;
        logic       va, vb, el, rst;
        int         s;
        for (int ep = 0; ep < 60; ep++) begin
            if (ep % 6 == 0) do_reset();
            s  = $urandom_range(0, c_MAX_SKEW + 1);
            el = 1'($urandom_range(0, 1));
            for (int i = 0; i < 64; i++) x[i] = ($urandom_range(0, 7) == 0) ? c_COM : junk();
            x[8] = c_COM;
            for (int i = 8; i < 48; i++) begin
                a = x[i];
                b = x[i - s];
                if ($urandom_range(0, 63) == 0) a = ($urandom_range(0, 1) == 1) ? c_COM : junk();
                va  = ($urandom_range(0, 19) != 0);
                vb  = ($urandom_range(0, 19) != 0);
                rst = ($urandom_range(0, 199) == 0);
                if (el) run_cycle(rst, b, vb, a, va);
                else    run_cycle(rst, a, va, b, vb);
                tests++;
                if (obs_vec !== exp_vec) begin
                    fails++;
                    $display("FAIL random_ep%0d_cyc%0d: observed %h, required %h", ep, i, obs_vec, exp_vec);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int pulses;
        do_reset();
        pulses = 0;
        for (int t = 0; t < 300; t++) begin
            run_cycle(1'b0, c_COM, 1'b1, junk(), 1'b1);
            if (o_err) pulses++;
            for (int k = 1; k <= c_MAX_SKEW; k++) begin
                run_cycle(1'b0, junk(), 1'b1, junk(), 1'b1);
                if (o_err) pulses++;
            end
        end
        run_cycle(1'b0, junk(), 1'b1, junk(), 1'b1);
        tests++;
        if (pulses !== 300) begin
            fails++;
            $display("FAIL saturation_pulses: observed %0d, required 300", pulses);
        end
        tests++;
        if (o_ec !== c_EC_SAT) begin
            fails++;
            $display("FAIL saturation_count: observed %h, required %h", o_ec, c_EC_SAT);
        end
        tests++;
        if (obs_vec !== exp_vec) begin
            fails++;
            $display("FAIL saturation_model: observed %h, required %h", obs_vec, exp_vec);
        end
    endtask

    initial begin : p_watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        for (int i = 0; i < 16; i++) begin
            hd0[i] = 8'h00; hd1[i] = 8'h00; hv0[i] = 1'b0; hv1[i] = 1'b0;
        end
        repeat (2) @(posedge clk_f);
        #1;
        test_reset();
        test_same_cycle();
        test_skew2();
        test_timeout();
        test_locked_err();
        test_reset_abort();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
